// File: rtl/lshift_seq_pkg.sv
// lshift_seq_pkg: definitions shared by the sequential ALU shifters.
//   state_t   - FSM state encoding (ST_IDLE, ST_SHIFT, ST_DONE)
//   FILL_*    - fill-select encoding; the right shifter uses the same values
//   clog2     - ceiling log2 for toolflows that lack $clog2
package lshift_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam logic FILL_ZERO = 1'b0;
  localparam logic FILL_ONE  = 1'b1;

  function automatic int clog2(input int value);
    int res;
    res = 0;
    while ((1 << res) < value) res++;
    return res;
  endfunction

endpackage

// File: rtl/lshift_seq.sv
// lshift_seq: multi-cycle logical left shifter, one bit per clock.
//   clk, rst    - clock (rising edge), synchronous active-high reset
//   start       - request, sampled only in IDLE
//   a, b        - operand and unsigned shift amount
//   aluflagin   - bit shifted in at the LSB (FILL_ZERO / FILL_ONE)
//   aluresult   - shifted result, valid with done, held until next start
//   aluflags    - last bit shifted out of the MSB, same validity
//   busy        - high while shifting
//   done        - single-cycle completion pulse
// All outputs are registers; the comb block computes every next value.
module lshift_seq
  import lshift_seq_pkg::*;
#(
  parameter int ancho = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [ancho-1:0] a,
  input  logic [ancho-1:0] b,
  input  logic             aluflagin,
  output logic [ancho-1:0] aluresult,
  output logic             aluflags,
  output logic             busy,
  output logic             done
);

  // Must hold ancho+1, the capped amount.
  localparam int CNTW = $clog2(ancho + 2);

  state_t            r_state, w_state_nxt;
  logic [ancho-1:0]  r_sreg,  w_sreg_nxt;
  logic              r_fill,  w_fill_nxt;
  logic [CNTW-1:0]   r_cnt,   w_cnt_nxt;
  logic [ancho-1:0]  r_result, w_result_nxt;
  logic              r_flags, w_flags_nxt;
  logic              r_busy,  w_busy_nxt;
  logic              r_done,  w_done_nxt;

  logic [CNTW-1:0]   w_amt;
  logic [ancho-1:0]  w_shifted;

  // Any amount past ancho+1 yields the same all-fill result and fill flag,
  // so capping keeps the counter small without changing the outcome.
  always_comb begin
    if (32'(b) > 32'(ancho + 1)) w_amt = CNTW'(ancho + 1);
    else                         w_amt = CNTW'(b);
  end

  assign w_shifted = {r_sreg[ancho-2:0], r_fill};

  always_comb begin
    w_state_nxt  = r_state;
    w_sreg_nxt   = r_sreg;
    w_fill_nxt   = r_fill;
    w_cnt_nxt    = r_cnt;
    w_result_nxt = r_result;
    w_flags_nxt  = r_flags;
    w_busy_nxt   = r_busy;
    w_done_nxt   = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_sreg_nxt  = a;
          w_fill_nxt  = aluflagin;
          w_flags_nxt = 1'b0;
          w_cnt_nxt   = w_amt;
          if (w_amt != '0) begin
            w_busy_nxt  = 1'b1;
            w_state_nxt = ST_SHIFT;
          end else begin
            // Zero shift: skip straight to completion, busy never rises.
            w_result_nxt = a;
            w_done_nxt   = 1'b1;
            w_state_nxt  = ST_DONE;
          end
        end
      end
      ST_SHIFT: begin
        w_flags_nxt = r_sreg[ancho-1];
        w_sreg_nxt  = w_shifted;
        w_cnt_nxt   = r_cnt - CNTW'(1);
        if (r_cnt == CNTW'(1)) begin
          w_result_nxt = w_shifted;
          w_busy_nxt   = 1'b0;
          w_done_nxt   = 1'b1;
          w_state_nxt  = ST_DONE;
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_sreg   <= '0;
      r_fill   <= FILL_ZERO;
      r_cnt    <= '0;
      r_result <= '0;
      r_flags  <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_sreg   <= w_sreg_nxt;
      r_fill   <= w_fill_nxt;
      r_cnt    <= w_cnt_nxt;
      r_result <= w_result_nxt;
      r_flags  <= w_flags_nxt;
      r_busy   <= w_busy_nxt;
      r_done   <= w_done_nxt;
    end
  end

  assign aluresult = r_result;
  assign aluflags  = r_flags;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule

// File: tb/tb_lshift_seq.sv
// tb_lshift_seq: self-checking bench for lshift_seq (ancho = 4).
// Expected values come from the arithmetic definition of a logical left shift.
module tb_lshift_seq;

  localparam int W   = 4;
  localparam int MAXW = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         aluflagin;
  logic [W-1:0] aluresult;
  logic         aluflags;
  logic         busy;
  logic         done;

  int checks = 0;
  int errors = 0;

  lshift_seq #(.ancho(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .a         (a),
    .b         (b),
    .aluflagin (aluflagin),
    .aluresult (aluresult),
    .aluflags  (aluflags),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  // Reference: result = (a << b) | fill mask, flag = last bit pushed out.
  function automatic logic [W-1:0] ref_result(input logic [W-1:0] va,
                                              input int vb, input logic vf);
    logic [W-1:0] ones;
    ones = '1;
    return (va << vb) | (vf ? ~(ones << vb) : '0);
  endfunction

  function automatic logic ref_flag(input logic [W-1:0] va,
                                    input int vb, input logic vf);
    if (vb == 0) return 1'b0;
    if (vb > W)  return vf;
    return va[W - vb];
  endfunction

  function automatic int ref_latency(input int vb);
    return ((vb > W + 1) ? W + 1 : vb) + 1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Launch one operation from IDLE and check latency, busy span, result,
  // flag and hold-after-done. Inputs are scrambled after the start edge.
  task automatic do_op(input logic [W-1:0] va, input logic [W-1:0] vb,
                       input logic vf, input string name);
    int lat, got_lat, busy_cnt;
    logic [W-1:0] er;
    logic ef;
    lat = ref_latency(int'(vb));
    er  = ref_result(va, int'(vb), vf);
    ef  = ref_flag(va, int'(vb), vf);
    a = va; b = vb; aluflagin = vf; start = 1'b1;
    tick();
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); aluflagin = 1'($urandom);
    got_lat = 0; busy_cnt = 0;
    for (int k = 1; k <= 12 && got_lat == 0; k++) begin
      if (busy) busy_cnt++;
      if (done) got_lat = k;
      else tick();
    end
    checks++;
    if (got_lat !== lat) begin
      errors++;
      $display("FAIL %s latency: got %0d expected %0d", name, got_lat, lat);
    end
    checks++;
    if (busy_cnt !== lat - 1) begin
      errors++;
      $display("FAIL %s busy_cycles: got %0d expected %0d", name, busy_cnt, lat - 1);
    end
    checks++;
    if (aluresult !== er) begin
      errors++;
      $display("FAIL %s result: got %b expected %b", name, aluresult, er);
    end
    checks++;
    if (aluflags !== ef) begin
      errors++;
      $display("FAIL %s flag: got %b expected %b", name, aluflags, ef);
    end
    tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || aluresult !== er || aluflags !== ef) begin
      errors++;
      $display("FAIL %s hold: got done=%b busy=%b res=%b flag=%b expected 0 0 %b %b",
               name, done, busy, aluresult, aluflags, er, ef);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; a = '0; b = '0; aluflagin = 1'b0;
    tick(); tick();
    checks++;
    if (aluresult !== '0 || aluflags !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset: got res=%b flag=%b busy=%b done=%b expected all zero",
               aluresult, aluflags, busy, done);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_directed();
    do_op(4'b1011, 4'd1, 1'b0, "b1_fill0");
    do_op(4'b1011, 4'd2, 1'b1, "b2_fill1");
    do_op(4'b1011, 4'd0, 1'b1, "b0");
    do_op(4'b1011, 4'd4, 1'b0, "b4_full");
    do_op(4'b1011, 4'd5, 1'b0, "b5_cap_edge");
    do_op(4'b1011, 4'd9, 1'b1, "b9_capped");
    do_op(4'b0100, 4'd15, 1'b0, "b15_capped");
  endtask

  task automatic test_random();
    for (int i = 0; i < 30; i++)
      do_op(W'($urandom), W'($urandom), 1'($urandom), "random");
  endtask

  // A second start while shifting must neither queue nor disturb the op.
  task automatic test_ignore_start();
    int ndone, first;
    logic [W-1:0] first_res;
    a = 4'b1011; b = 4'd3; aluflagin = 1'b0; start = 1'b1;
    tick();
    a = 4'b0001; b = 4'd1; aluflagin = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    ndone = 0; first = 0; first_res = '0;
    for (int k = 2; k <= 12; k++) begin
      if (done) begin
        ndone++;
        if (first == 0) begin first = k; first_res = aluresult; end
      end
      tick();
    end
    checks++;
    if (ndone !== 1 || first !== 4) begin
      errors++;
      $display("FAIL ignore_start: got %0d dones first at %0d expected 1 at 4", ndone, first);
    end
    checks++;
    if (first_res !== ref_result(4'b1011, 3, 1'b0)) begin
      errors++;
      $display("FAIL ignore_start result: got %b expected %b",
               first_res, ref_result(4'b1011, 3, 1'b0));
    end
  endtask

  // Start held high: operations repeat, each separated by one IDLE cycle.
  task automatic test_back_to_back();
    int pos[$];
    int lat;
    logic [W-1:0] er;
    int nbad;
    lat = ref_latency(2);
    er  = ref_result(4'b0110, 2, 1'b1);
    nbad = 0;
    a = 4'b0110; b = 4'd2; aluflagin = 1'b1; start = 1'b1;
    tick();
    for (int k = 1; k <= 11; k++) begin
      if (done) begin
        pos.push_back(k);
        if (aluresult !== er) nbad++;
      end
      tick();
    end
    start = 1'b0;
    tick(); tick();
    checks++;
    if (pos.size() !== 3 || pos[0] !== lat || pos[1] !== 2 * lat + 1 || pos[2] !== 3 * lat + 2) begin
      errors++;
      $display("FAIL back_to_back timing: got %0d dones expected 3 at %0d,%0d,%0d",
               pos.size(), lat, 2 * lat + 1, 3 * lat + 2);
    end
    checks++;
    if (nbad !== 0) begin
      errors++;
      $display("FAIL back_to_back result: got %0d bad results expected 0", nbad);
    end
  endtask

  task automatic test_reset_mid();
    int ndone;
    a = 4'b1011; b = 4'd3; aluflagin = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (aluresult !== '0 || aluflags !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: got res=%b flag=%b busy=%b done=%b expected all zero",
               aluresult, aluflags, busy, done);
    end
    ndone = 0;
    for (int k = 0; k < 6; k++) begin
      if (done || busy) ndone++;
      tick();
    end
    checks++;
    if (ndone !== 0) begin
      errors++;
      $display("FAIL reset_mid abort: got %0d active cycles expected 0", ndone);
    end
    do_op(4'b1101, 4'd3, 1'b0, "after_reset");
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
